// File: rtl/pbch_re_index_gen.sv
// pbch_re_index_gen: walks SSB symbols 1-3 of the PBCH region and emits one (symbol, subcarrier) RE index per
// accepted beat. EMIT_DMRS=0 skips the DMRS subcarriers; EMIT_DMRS=1 emits every RE and flags the DMRS ones.
module pbch_re_index_gen #(
   parameter bit EMIT_DMRS = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       idx_start,
   input  logic [9:0] ncellid,
   input  logic       re_rdy,
   output logic       re_vld,
   output logic [1:0] re_sym,
   output logic [7:0] re_sc,
   output logic       re_is_dmrs,
   output logic       re_last,
   output logic       idx_done,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, SYM1, SYM2, SYM3, DONE} state_t;
   localparam logic DATA_ONLY = !EMIT_DMRS;
   state_t st_q, st_d;
   logic vld_q, vld_d, up_q, up_d, busy_q, busy_d;
   logic [1:0] sym_q, sym_d, v_q, v_d;
   logic [7:0] sc_q, sc_d;
   logic [8:0] s1, s2, lim;
   logic bend, skip, acc;
   logic unused_id;
   assign unused_id = ^ncellid[9:2];
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= IDLE;
         vld_q  <= 1'b0;
         up_q   <= 1'b0;
         busy_q <= 1'b0;
         sym_q  <= 2'd0;
         v_q    <= 2'd0;
         sc_q   <= 8'd0;
      end else begin
         st_q   <= st_d;
         vld_q  <= vld_d;
         up_q   <= up_d;
         busy_q <= busy_d;
         sym_q  <= sym_d;
         v_q    <= v_d;
         sc_q   <= sc_d;
      end
   end
   // 9-bit successor so that the +2 skip past a DMRS RE at 239 cannot wrap
   always_comb begin
      s1     = {1'b0, sc_q} + 9'd1;
      s2     = (DATA_ONLY && s1[1:0] == v_q) ? s1 + 9'd1 : s1;
      lim    = (st_q == SYM2 && !up_q) ? 9'd47 : 9'd239;
      bend   = s2 > lim;
      skip   = DATA_ONLY && v_q == 2'd0;
      acc    = vld_q && re_rdy;
      st_d   = st_q;
      vld_d  = vld_q;
      up_d   = up_q;
      busy_d = busy_q;
      sym_d  = sym_q;
      v_d    = v_q;
      sc_d   = sc_q;
      case (st_q)
         IDLE: if (idx_start) begin
            st_d   = SYM1;
            v_d    = ncellid[1:0];
            vld_d  = 1'b1;
            busy_d = 1'b1;
            sym_d  = 2'd1;
            up_d   = 1'b0;
            sc_d   = {7'd0, DATA_ONLY && ncellid[1:0] == 2'd0};
         end
         DONE: begin
            st_d   = IDLE;
            busy_d = 1'b0;
         end
         default: if (acc) begin
            if (!bend) sc_d = s2[7:0];
            else if (st_q == SYM1 || (st_q == SYM2 && up_q)) begin
               st_d  = (st_q == SYM1) ? SYM2 : SYM3;
               sym_d = sym_q + 2'd1;
               up_d  = 1'b0;
               sc_d  = {7'd0, skip};
            end else if (st_q == SYM2) begin
               up_d = 1'b1;
               sc_d = 8'd192 | {7'd0, skip};
            end else begin
               st_d  = DONE;
               vld_d = 1'b0;
            end
         end
      endcase
   end
   assign re_vld     = vld_q;
   assign re_sym     = sym_q;
   assign re_sc      = sc_q;
   assign re_is_dmrs = EMIT_DMRS && vld_q && sc_q[1:0] == v_q;
   assign re_last    = vld_q && st_q == SYM3 && bend;
   assign idx_done   = st_q == DONE;
   assign busy       = busy_q;
endmodule
